// File: rtl/digit_glyph_decoder.sv
// Incremental 5x5 digit glyph recogniser: one row per accepted beat narrows a candidate mask.
// Optional macro DIGIT_DECODE_SOF_EN adds a row_sof input that reframes glyphs on a start-of-frame flag.
module digit_glyph_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] row_in,
  input  logic       row_valid,
  output logic       row_ready,
`ifdef DIGIT_DECODE_SOF_EN
  input  logic       row_sof,
`endif
  output logic       result_valid,
  input  logic       result_ready,
  output logic [3:0] digit,
  output logic       match
);

  typedef enum logic {COLLECT, RESULT} state_t;

  localparam logic [4:0] FONT [10][5] = '{
    '{5'h1F, 5'h11, 5'h11, 5'h11, 5'h1F},
    '{5'h0C, 5'h04, 5'h04, 5'h04, 5'h1F},
    '{5'h1F, 5'h01, 5'h1F, 5'h10, 5'h1F},
    '{5'h1F, 5'h01, 5'h1F, 5'h01, 5'h1F},
    '{5'h11, 5'h11, 5'h1F, 5'h01, 5'h01},
    '{5'h1F, 5'h10, 5'h1F, 5'h01, 5'h1F},
    '{5'h1F, 5'h10, 5'h1F, 5'h11, 5'h1F},
    '{5'h1F, 5'h01, 5'h01, 5'h01, 5'h01},
    '{5'h1F, 5'h11, 5'h1F, 5'h11, 5'h1F},
    '{5'h1F, 5'h11, 5'h1F, 5'h01, 5'h1F}
  };

  state_t     state_q, state_d;
  logic [9:0] cand_q, cand_d;
  logic [2:0] row_idx_q, row_idx_d;
  logic [3:0] digit_q, digit_d;
  logic       match_q, match_d;

  logic [9:0] base_cand;
  logic [2:0] base_idx;
  logic       take_row;
  logic [9:0] row_hit;
  logic [9:0] filt;
  logic [3:0] found_digit;
  logic       found_match;

  // Framing: a start-of-frame row rewinds to row 0 before filtering.
  always_comb begin
    base_cand = cand_q;
    base_idx  = row_idx_q;
    take_row  = (state_q == COLLECT) && row_valid;
`ifdef DIGIT_DECODE_SOF_EN
    if (row_sof) begin
      base_cand = 10'h3FF;
      base_idx  = 3'd0;
    end else if (row_idx_q == 3'd0) begin
      take_row = 1'b0;
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_hit
      assign row_hit[gi] = (FONT[gi][base_idx] == row_in);
    end
  endgenerate

  assign filt = base_cand & row_hit;

  // Glyphs are pairwise distinct, so at most one bit survives all five rows.
  always_comb begin
    found_digit = 4'hF;
    found_match = 1'b0;
    for (int d = 0; d < 10; d++) begin
      if (filt[d]) begin
        found_digit = 4'(d);
        found_match = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    row_idx_d = row_idx_q;
    digit_d   = digit_q;
    match_d   = match_q;
    case (state_q)
      COLLECT: begin
        if (take_row) begin
          cand_d = filt;
          if (base_idx == 3'd4) begin
            state_d = RESULT;
            digit_d = found_digit;
            match_d = found_match;
          end else begin
            row_idx_d = base_idx + 3'd1;
          end
        end
      end
      RESULT: begin
        if (result_ready) begin
          state_d   = COLLECT;
          cand_d    = 10'h3FF;
          row_idx_d = 3'd0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= COLLECT;
      cand_q    <= 10'h3FF;
      row_idx_q <= 3'd0;
      digit_q   <= 4'h0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      row_idx_q <= row_idx_d;
      digit_q   <= digit_d;
      match_q   <= match_d;
    end
  end

  assign row_ready    = (state_q == COLLECT);
  assign result_valid = (state_q == RESULT);
  assign digit        = digit_q;
  assign match        = match_q;

endmodule

// File: tb/tb_digit_glyph_decoder.sv
// Directed, table-driven bench for digit_glyph_decoder; define DIGIT_DECODE_SOF_EN to cover row_sof framing.
module tb_digit_glyph_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] row_in = 5'h00;
  logic       row_valid = 1'b0;
  logic       row_ready;
  logic       result_valid;
  logic       result_ready = 1'b1;
  logic [3:0] digit;
  logic       match;
`ifdef DIGIT_DECODE_SOF_EN
  logic       row_sof = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [24:0] rows;
    logic [3:0]  exp_digit;
    logic        exp_match;
  } vec_t;

  vec_t vecs [12];

  digit_glyph_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .row_in       (row_in),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
`ifdef DIGIT_DECODE_SOF_EN
    .row_sof      (row_sof),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .digit        (digit),
    .match        (match)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents five rows; with gap > 0, row_valid drops for gap cycles between rows.
  task automatic send_rows(input logic [24:0] g, input int gap);
    for (int i = 0; i < 5; i++) begin
      row_valid = 1'b1;
      row_in    = g[24 - 5*i -: 5];
      chk("row_ready_collect", 32'(row_ready), 32'd1);
      step();
      if (i < 4) begin
        chk("no_early_result", 32'(result_valid), 32'd0);
        if (gap > 0) begin
          row_valid = 1'b0;
          row_in    = 5'($urandom_range(0, 31));
          repeat (gap) step();
        end
      end
    end
  endtask

  task automatic chk_result(input string name, input logic [3:0] d, input logic m);
    chk({name, "_valid"}, 32'(result_valid), 32'd1);
    chk({name, "_digit"}, 32'(digit), 32'(d));
    chk({name, "_match"}, 32'(match), 32'(m));
    chk({name, "_rdy_low"}, 32'(row_ready), 32'd0);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    step();
    chk("post_hs_valid", 32'(result_valid), 32'd0);
    chk("post_hs_ready", 32'(row_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    chk("rst_row_ready", 32'(row_ready), 32'd1);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    int prev_t;
    int t;

    vecs[0]  = '{25'h0, 4'd0, 1'b1};
    vecs[0].rows  = {5'h1F, 5'h11, 5'h11, 5'h11, 5'h1F};
    vecs[1].rows  = {5'h0C, 5'h04, 5'h04, 5'h04, 5'h1F};
    vecs[2].rows  = {5'h1F, 5'h01, 5'h1F, 5'h10, 5'h1F};
    vecs[3].rows  = {5'h1F, 5'h01, 5'h1F, 5'h01, 5'h1F};
    vecs[4].rows  = {5'h11, 5'h11, 5'h1F, 5'h01, 5'h01};
    vecs[5].rows  = {5'h1F, 5'h10, 5'h1F, 5'h01, 5'h1F};
    vecs[6].rows  = {5'h1F, 5'h10, 5'h1F, 5'h11, 5'h1F};
    vecs[7].rows  = {5'h1F, 5'h01, 5'h01, 5'h01, 5'h01};
    vecs[8].rows  = {5'h1F, 5'h11, 5'h1F, 5'h11, 5'h1F};
    vecs[9].rows  = {5'h1F, 5'h11, 5'h1F, 5'h01, 5'h1F};
    for (int k = 0; k < 10; k++) begin
      vecs[k].exp_digit = 4'(k);
      vecs[k].exp_match = 1'b1;
    end
    vecs[10] = '{{5'h1F, 5'h11, 5'h1F, 5'h11, 5'h1E}, 4'hF, 1'b0};
    vecs[11] = '{{5'h0C, 5'h04, 5'h04, 5'h04, 5'h1F}, 4'd1, 1'b1};

    // Reset state, then a single glyph 9.
    do_reset();
    send_rows(vecs[9].rows, 0);
    chk_result("g9", 4'd9, 1'b1);
    row_valid = 1'b0;
    handshake();

    // All table glyphs back to back with row_valid held high: one result per 6 cycles.
    prev_t = 0;
    for (int k = 0; k < 12; k++) begin
      send_rows(vecs[k].rows, 0);
      chk_result($sformatf("tbl%0d", k), vecs[k].exp_digit, vecs[k].exp_match);
      t = cyc;
      if (k > 0) chk("period", 32'(t - prev_t), 32'd6);
      prev_t = t;
      step();
    end
    row_valid = 1'b0;
    step();

    // Result held with result_ready low while rows are offered: nothing consumed.
    send_rows(vecs[7].rows, 0);
    result_ready = 1'b0;
    row_in = 5'h1F;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_rdy", 32'(row_ready), 32'd0);
      chk("hold_digit", 32'(digit), 32'd7);
      chk("hold_valid", 32'(result_valid), 32'd1);
    end
    row_valid = 1'b0;
    handshake();
    send_rows(vecs[0].rows, 0);
    chk_result("after_hold", 4'd0, 1'b1);
    row_valid = 1'b0;
    handshake();

    // Reset after 3 rows of glyph 2, then glyph 3.
    for (int i = 0; i < 3; i++) begin
      row_valid = 1'b1;
      row_in = vecs[2].rows[24 - 5*i -: 5];
      step();
    end
    row_valid = 1'b0;
    do_reset();
    send_rows(vecs[3].rows, 0);
    chk_result("after_rst", 4'd3, 1'b1);
    row_valid = 1'b0;

    // Reset while a result is pending.
    result_ready = 1'b0;
    step();
    do_reset();
    result_ready = 1'b1;

    // Gaps between rows hold state.
    send_rows(vecs[5].rows, 2);
    chk_result("gaps", 4'd5, 1'b1);
    row_valid = 1'b0;
    handshake();

`ifdef DIGIT_DECODE_SOF_EN
    // Leading non-sof row dropped, aborted 2-row glyph, then sof-framed glyph 4.
    do_reset();
    row_valid = 1'b1;
    row_sof = 1'b0; row_in = 5'h1F; step();
    row_sof = 1'b1; row_in = 5'h1F; step();
    row_sof = 1'b0; row_in = 5'h10; step();
    chk("sof_no_result", 32'(result_valid), 32'd0);
    row_sof = 1'b1; row_in = 5'h11; step();
    row_sof = 1'b0;
    row_in = 5'h11; step();
    row_in = 5'h1F; step();
    row_in = 5'h01; step();
    chk("sof_not_yet", 32'(result_valid), 32'd0);
    row_in = 5'h01; step();
    chk_result("sof", 4'd4, 1'b1);
    row_valid = 1'b0;
    handshake();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
